// File: rtl/out_bcd_display.sv
// -----------------------------------------------------------------------------
// out_bcd_display
//
// Watches the CPU output word and, whenever it changes, converts it to packed
// BCD with a sequential double-dabble engine (one bit per clock). The result is
// held in a register and decoded into one 7-segment pattern per decimal digit.
//
// Ports:
//   clk    in   1             system clock, rising edge
//   rst    in   1             asynchronous, active-high reset
//   in     in   DATA_WIDTH    watched CPU output word, sampled every cycle
//   bcd    out  4*DIGITS      packed BCD, digit 0 (units) in bits [3:0]
//   seg    out  7*DIGITS      segments gfedcba, active-high, digit 0 in [6:0]
//   neg    out  1             sign of the displayed value
//   busy   out  1             conversion in progress
//   valid  out  1             one-cycle pulse when bcd/seg/neg update
//
// Build option:
//   OUT_BCD_SIGNED_EN  when defined, `in` is two's complement: negative values
//                      are converted as their magnitude and `neg` reports the
//                      sign. When undefined, `in` is unsigned and `neg` is 0.
//
// Timing (capture edge = E0): shifts happen on E1..E_DATA_WIDTH, the engine
// sits in DONE for one cycle and the registered outputs plus `valid` appear
// after edge E_DATA_WIDTH+1. The cycle in which `valid` is high is already an
// IDLE cycle internally, so a new value can be captured at its closing edge;
// this gives the DATA_WIDTH+2 minimum spacing between `valid` pulses.
// -----------------------------------------------------------------------------
module out_bcd_display #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in,
    output logic [4*DIGITS-1:0]     bcd,
    output logic [7*DIGITS-1:0]     seg,
    output logic                    neg,
    output logic                    busy,
    output logic                    valid
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Double-dabble correction: every digit >= 5 gets +3 before the shift so
    // that the shift carries it correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    // One BCD nibble to gfedcba, active-high; non-decimal nibbles go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

`ifdef OUT_BCD_SIGNED_EN
    // Magnitude of a two's complement word; the most negative value maps onto
    // itself, which read as unsigned is exactly 2^(DATA_WIDTH-1).
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] m;
        if (v[DATA_WIDTH-1]) begin
            m = ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction
`endif

    logic [1:0]            state_r,   state_s;
    logic [DATA_WIDTH-1:0] last_r,    last_s;
    logic [DATA_WIDTH-1:0] shift_r,   shift_s;
    logic [BCD_W-1:0]      scratch_r, scratch_s;
    logic [CNT_W-1:0]      cnt_r,     cnt_s;
    logic [BCD_W-1:0]      bcd_r,     bcd_s;
    logic                  busy_r,    busy_s;
    logic                  valid_r,   valid_s;
    logic [BCD_W-1:0]      adj_s;
`ifdef OUT_BCD_SIGNED_EN
    logic                  sign_r,    sign_s;
    logic                  neg_r,     neg_s;
`endif

    // Next-state logic for the conversion engine and output registers.
    always_comb begin
        state_s   = state_r;
        last_s    = last_r;
        shift_s   = shift_r;
        scratch_s = scratch_r;
        cnt_s     = cnt_r;
        bcd_s     = bcd_r;
        valid_s   = 1'b0;
        adj_s     = add3_digits(scratch_r);
`ifdef OUT_BCD_SIGNED_EN
        sign_s    = sign_r;
        neg_s     = neg_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (in != last_r) begin
                    last_s    = in;
`ifdef OUT_BCD_SIGNED_EN
                    shift_s   = magnitude(in);
                    sign_s    = in[DATA_WIDTH-1];
`else
                    shift_s   = in;
`endif
                    scratch_s = '0;
                    cnt_s     = '0;
                    state_s   = ST_SHIFT;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Top BCD bit falls off: excess high-order digits truncate.
                scratch_s = {adj_s[BCD_W-2:0], shift_r[DATA_WIDTH-1]};
                shift_s   = {shift_r[DATA_WIDTH-2:0], 1'b0};
                cnt_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                bcd_s   = scratch_r;
`ifdef OUT_BCD_SIGNED_EN
                neg_s   = sign_r;
`endif
                valid_s = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Busy covers the whole conversion including the cycle valid is shown.
        busy_s = (state_s != ST_IDLE) || valid_s;
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            last_r    <= '0;
            shift_r   <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            bcd_r     <= '0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
`ifdef OUT_BCD_SIGNED_EN
            sign_r    <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            last_r    <= last_s;
            shift_r   <= shift_s;
            scratch_r <= scratch_s;
            cnt_r     <= cnt_s;
            bcd_r     <= bcd_s;
            busy_r    <= busy_s;
            valid_r   <= valid_s;
`ifdef OUT_BCD_SIGNED_EN
            sign_r    <= sign_s;
            neg_r     <= neg_s;
`endif
        end
    end

    // Per-digit segment decode of the registered BCD value.
    always_comb begin
        seg = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = seg_decode(bcd_r[4*i +: 4]);
        end
    end

    assign bcd   = bcd_r;
    assign busy  = busy_r;
    assign valid = valid_r;
`ifdef OUT_BCD_SIGNED_EN
    assign neg   = neg_r;
`else
    assign neg   = 1'b0;
`endif

endmodule

// File: tb/tb_out_bcd_display.sv
// -----------------------------------------------------------------------------
// tb_out_bcd_display
//
// Directed bench for out_bcd_display: reset state, conversion latency, value
// hold, overlap of a new value during a conversion, mid-conversion reset and,
// depending on OUT_BCD_SIGNED_EN, the unsigned maximum or the signed cases.
// -----------------------------------------------------------------------------
module tb_out_bcd_display;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic [19:0] bcd;
    logic [34:0] seg;
    logic        neg;
    logic        busy;
    logic        valid;

    int checks   = 0;
    int failures = 0;
    int n;
    int vcnt;
    int bcnt;

    localparam logic [34:0] SEG_ZERO = {5{7'b0111111}};
    // Digits 4..0 = 0,1,2,3,4
    localparam logic [34:0] SEG_1234 = {7'b0111111, 7'b0000110, 7'b1011011,
                                        7'b1001111, 7'b1100110};

    out_bcd_display #(.DATA_WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .bcd   (bcd),
        .seg   (seg),
        .neg   (neg),
        .busy  (busy),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges until valid is seen high (1 = first edge); 0 if none within budget.
    task automatic wait_valid(output int edges);
        edges = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (valid) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in  = 16'd0;
        repeat (3) tick();

        // Reset state
        check("rst_bcd",   64'(bcd),   64'h0);
        check("rst_seg",   64'(seg),   64'(SEG_ZERO));
        check("rst_neg",   64'(neg),   64'h0);
        check("rst_busy",  64'(busy),  64'h0);
        check("rst_valid", 64'(valid), 64'h0);

        rst  = 1'b0;
        vcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid) vcnt++;
            if (busy)  bcnt++;
        end
        check("idle0_valid_count", 64'(vcnt), 64'h0);
        check("idle0_busy_count",  64'(bcnt), 64'h0);
        check("idle0_bcd",         64'(bcd),  64'h0);

        // 1234: busy right after capture, valid after 17 more edges
        in = 16'd1234;
        tick();
        check("c1234_busy_e0", 64'(busy), 64'h1);
        check("c1234_valid_e0", 64'(valid), 64'h0);
        wait_valid(n);
        check("c1234_latency", 64'(n),   64'd17);
        check("c1234_bcd",     64'(bcd), 64'h01234);
        check("c1234_seg",     64'(seg), 64'(SEG_1234));
        check("c1234_busy_valid", 64'(busy), 64'h1);
        tick();
        check("c1234_valid_pulse", 64'(valid), 64'h0);
        check("c1234_busy_off",    64'(busy),  64'h0);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid) vcnt++;
        end
        check("c1234_hold_no_valid", 64'(vcnt), 64'h0);
        check("c1234_hold_bcd",      64'(bcd),  64'h01234);

`ifdef OUT_BCD_SIGNED_EN
        in = 16'hFFFF;
        wait_valid(n);
        check("sFFFF_latency", 64'(n),   64'd18);
        check("sFFFF_bcd",     64'(bcd), 64'h00001);
        check("sFFFF_neg",     64'(neg), 64'h1);
        tick();
        in = 16'h8000;
        wait_valid(n);
        check("s8000_latency", 64'(n),   64'd18);
        check("s8000_bcd",     64'(bcd), 64'h32768);
        check("s8000_neg",     64'(neg), 64'h1);
        tick();
        in = 16'd7;
        wait_valid(n);
        check("s7_bcd", 64'(bcd), 64'h00007);
        check("s7_neg", 64'(neg), 64'h0);
        check("s7_seg0", 64'(seg[6:0]), 64'(7'b0000111));
        tick();
`else
        in = 16'd65535;
        wait_valid(n);
        check("u65535_latency", 64'(n),   64'd18);
        check("u65535_bcd",     64'(bcd), 64'h65535);
        check("u65535_neg",     64'(neg), 64'h0);
        check("u65535_seg4",    64'(seg[34:28]), 64'(7'b1111101));
        tick();
`endif

        // 10, then 20 arriving mid-conversion: 10 finishes, 20 follows at once
        in = 16'd10;
        tick();                 // E0
        repeat (4) tick();      // E1..E4
        in = 16'd20;
        wait_valid(n);
        check("ovl_first_latency", 64'(n),   64'd13);
        check("ovl_first_bcd",     64'(bcd), 64'h00010);
        wait_valid(n);
        check("ovl_spacing",       64'(n),   64'd18);
        check("ovl_second_bcd",    64'(bcd), 64'h00020);
        tick();
        check("ovl_idle_busy",     64'(busy), 64'h0);

        // Reset in the middle of converting 999
        in = 16'd999;
        tick();                 // E0
        repeat (8) tick();      // E1..E8
        check("mid_busy_before_rst", 64'(busy), 64'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  64'(busy),  64'h0);
        check("mid_rst_bcd",   64'(bcd),   64'h0);
        check("mid_rst_seg",   64'(seg),   64'(SEG_ZERO));
        vcnt = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (valid) vcnt++;
        end
        check("mid_rst_no_valid", 64'(vcnt), 64'h0);
        rst = 1'b0;
        wait_valid(n);
        check("post_rst_latency", 64'(n),   64'd18);
        check("post_rst_bcd",     64'(bcd), 64'h00999);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
